// File: rtl/toothless_pkg.sv
// Shared types and constants for the instruction-memory responder.
package toothless_pkg;

  // Access sequencing: accept -> wait states -> array read -> queue push
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    PUSH = 2'd3
  } imem_state_e;

  // RISC-V "addi x0, x0, 0"; returned in place of data on address errors
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned IMEM_INSTR_W = 32;

  // One response-queue entry
  typedef struct packed {
    logic [IMEM_INSTR_W-1:0] data;
    logic                    err;
  } imem_resp_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with show-ahead head, synchronous clear and
// occupancy count. Push and pop in the same cycle are both honoured when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = store[rd_ptr_reg];
  assign do_push  = push && !clr && (!full || pop);
  assign do_pop   = pop && !clr && !empty;

  // Entry storage; no reset needed since occupancy is tracked separately
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally for power-of-two depth
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: one fetch at a time, programmable wait
// states, registered array read, valid/ready response queue, load port.
// Optional build macro IMEM_PARITY_EN adds a stored even-parity bit per word.
// The response in its PUSH cycle is presented directly when the queue is
// empty, giving an accept-to-rvalid latency of LATENCY+2 cycles.
module imem_responder
  import toothless_pkg::*;
#(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int                  LATENCY     = 1,
  parameter int                  RESP_DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_i,
  input  logic [ADDR_WIDTH-1:0]  addr_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [INSTR_WIDTH-1:0] rdata_o,
  output logic                   err_o,
  input  logic                   rready_i,
  input  logic                   flush_i,
  input  logic                   wr_en_i,
  input  logic [ADDR_WIDTH-1:0]  wr_addr_i,
  input  logic [INSTR_WIDTH-1:0] wr_data_i
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
`ifdef IMEM_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int MW = INSTR_WIDTH + PW;
  localparam int RW = INSTR_WIDTH + 1;

  // Word-aligned and inside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS)
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_ADDR};
    return (a[1:0] == 2'b00) && !diff[ADDR_WIDTH] &&
           ((diff[ADDR_WIDTH-1:0] >> 2) < ADDR_WIDTH'(DEPTH_WORDS));
  endfunction

  // Only meaningful after addr_ok; truncation cannot wrap for valid addresses
  function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  imem_state_e      state_reg;
  logic [3:0]       cnt_reg;
  logic [IW-1:0]    idx_reg;
  logic             addr_err_reg;
  logic [MW-1:0]    mem_array [DEPTH_WORDS];
  logic [MW-1:0]    rd_word_reg;

  logic             accept;
  logic             wr_ok;
  logic [MW-1:0]    wr_word;
  logic             par_err;
  logic [INSTR_WIDTH-1:0] resp_data;
  logic             resp_err;
  logic [RW-1:0]    push_word;
  logic [RW-1:0]    head_word;
  logic             bypass;

  logic             fifo_push;
  logic             fifo_pop;
  logic [RW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  // Grant only from IDLE with room for the new access in the queue
  assign gnt_o  = rst_n && (state_reg == IDLE) && !flush_i &&
                  (fifo_count < CW'(RESP_DEPTH));
  assign accept = req_i && gnt_o;
  assign wr_ok  = wr_en_i && addr_ok(wr_addr_i);

`ifdef IMEM_PARITY_EN
  assign wr_word = {^wr_data_i, wr_data_i};
  assign par_err = ^rd_word_reg;
`else
  assign wr_word = wr_data_i;
  assign par_err = 1'b0;
`endif

  // Address errors replace the word; parity errors keep the raw word
  assign resp_err  = addr_err_reg || par_err;
  assign resp_data = addr_err_reg ? INSTR_WIDTH'(NOP_INSTR) : rd_word_reg[INSTR_WIDTH-1:0];
  assign push_word = {resp_err, resp_data};

  // Access sequencer; flush and reset both abandon the access without a push
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      addr_err_reg <= 1'b0;
    end else if (flush_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            idx_reg      <= word_idx(addr_i);
            addr_err_reg <= !addr_ok(addr_i);
            cnt_reg      <= 4'(LATENCY);
            state_reg    <= (LATENCY == 0) ? READ : WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg <= 4'd1) state_reg <= READ;
        end
        READ:    state_reg <= PUSH;
        PUSH:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Instruction array: load-port write plus registered read (read-old-data)
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_array[word_idx(wr_addr_i)] <= wr_word;
    end
    if ((state_reg == READ) && !addr_err_reg) begin
      rd_word_reg <= mem_array[idx_reg];
    end
  end

  // PUSH data goes straight out when nothing is queued ahead of it; it only
  // enters the queue if the consumer does not take it in that cycle.
  assign bypass    = (state_reg == PUSH) && fifo_empty;
  assign fifo_pop  = !fifo_empty && rready_i;
  assign fifo_push = (state_reg == PUSH) && !flush_i &&
                     !(fifo_empty && rready_i) && (!fifo_full || fifo_pop);

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush_i),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_word = fifo_empty ? push_word : fifo_head;
  assign rvalid_o  = !fifo_empty || bypass;
  assign rdata_o   = rvalid_o ? head_word[INSTR_WIDTH-1:0] : '0;
  assign err_o     = rvalid_o && head_word[INSTR_WIDTH];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder with a response scoreboard.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        rready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [31:0] wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  imem_responder #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32),
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0000_0000),
    .LATENCY     (1),
    .RESP_DEPTH  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .addr_i    (addr_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .rready_i  (rready_i),
    .flush_i   (flush_i),
    .wr_en_i   (wr_en_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i)
  );

  always #5 clk = ~clk;

  // Response monitor: every handshake must match the oldest expectation
  always @(negedge clk) begin : mon
    logic [32:0] e;
    if (rst_n && rvalid_o && rready_i) begin
      n_tests++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_resp: observed err=%0b data=%h, required no response", err_o, rdata_o);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tests++;
        assert ({err_o, rdata_o} === e) else begin
          n_fail++;
          $error("FAIL resp: observed err=%0b data=%h, required err=%0b data=%h",
                 err_o, rdata_o, e[32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    tick();
    wr_en_i   = 1'b0;
  endtask

  // Returns at the negedge of the granting cycle, or after a bounded wait
  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (gnt_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic e, input bit scored);
    bit ok;
    req_i  = 1'b1;
    addr_i = a;
    wait_gnt(ok);
    check("gnt_wait", 64'(ok), 64'(1));
    if (ok && scored) exp_q.push_back({e, d});
    tick();
    req_i = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (exp_q.size() == 0) done = 1'b1;
    end
    check("drain_timeout", 64'(done), 64'(1));
  endtask

  initial begin
    bit ok;

    // Reset with a request pending: nothing granted, outputs quiet
    req_i = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_gnt",    64'(gnt_o),    64'(0));
    check("rst_rvalid", 64'(rvalid_o), 64'(0));
    check("rst_rdata",  64'(rdata_o),  64'(0));
    check("rst_err",    64'(err_o),    64'(0));
    tick();
    req_i = 1'b0;
    rst_n = 1'b1;

    // Program load, including a misaligned and an out-of-range write
    load(32'h0,    32'h0010_0093);
    load(32'h4,    32'h1111_1111);
    load(32'h8,    32'h2222_2222);
    load(32'h10,   32'h0000_0000);
    load(32'h6,    32'hBAD0_BAD0);
    load(32'h1000, 32'hBAD1_BAD1);

    // Cycle-exact first fetch: grant in cycle 0, response in cycle 3
    rready_i = 1'b1;
    req_i    = 1'b1;
    addr_i   = 32'h0;
    @(negedge clk);
    check("c0_gnt", 64'(gnt_o), 64'(1));
    exp_q.push_back({1'b0, 32'h0010_0093});
    tick();
    req_i = 1'b0;
    @(negedge clk);
    check("c1_rvalid", 64'(rvalid_o), 64'(0));
    @(negedge clk);
    check("c2_rvalid", 64'(rvalid_o), 64'(0));
    @(negedge clk);
    check("c3_rvalid", 64'(rvalid_o), 64'(1));
    tick();
    check("c3_consumed", 64'(exp_q.size()), 64'(0));

    // Plain fetch and address-error fetches
    fetch(32'h4,        32'h1111_1111, 1'b0, 1'b1); drain();
    fetch(32'h2,        NOP,           1'b1, 1'b1); drain();
    fetch(32'h1000,     NOP,           1'b1, 1'b1); drain();
    fetch(32'hFFFF_FFFC, NOP,          1'b1, 1'b1); drain();

    // Back-pressure: two responses queue up, the third request waits
    rready_i = 1'b0;
    fetch(32'h0, 32'h0010_0093, 1'b0, 1'b1);
    fetch(32'h4, 32'h1111_1111, 1'b0, 1'b1);
    req_i  = 1'b1;
    addr_i = 32'h8;
    repeat (6) tick();
    @(negedge clk);
    check("full_gnt",    64'(gnt_o),    64'(0));
    check("full_rvalid", 64'(rvalid_o), 64'(1));
    check("hold_data",   64'(rdata_o),  64'(32'h0010_0093));
    tick();
    @(negedge clk);
    check("hold_data2",  64'(rdata_o),  64'(32'h0010_0093));
    tick();
    rready_i = 1'b1;
    wait_gnt(ok);
    check("third_gnt", 64'(ok), 64'(1));
    if (ok) exp_q.push_back({1'b0, 32'h2222_2222});
    tick();
    req_i = 1'b0;
    drain();

    // Flush while the fetch of 0x4 is in its read cycle
    req_i  = 1'b1;
    addr_i = 32'h4;
    wait_gnt(ok);
    check("flush_acc_gnt", 64'(ok), 64'(1));
    tick();
    req_i = 1'b0;
    tick();
    flush_i = 1'b1;
    req_i   = 1'b1;
    addr_i  = 32'h8;
    @(negedge clk);
    check("flush_gnt", 64'(gnt_o), 64'(0));
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_rvalid", 64'(rvalid_o), 64'(0));
    check("post_flush_gnt", 64'(gnt_o), 64'(1));
    exp_q.push_back({1'b0, 32'h2222_2222});
    tick();
    req_i = 1'b0;
    drain();

    // Flush with two responses queued: both are discarded
    rready_i = 1'b0;
    fetch(32'h0, 32'h0, 1'b0, 1'b0);
    fetch(32'h4, 32'h0, 1'b0, 1'b0);
    repeat (6) tick();
    @(negedge clk);
    check("queued_rvalid", 64'(rvalid_o), 64'(1));
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    check("qflush_rvalid", 64'(rvalid_o), 64'(0));
    check("qflush_gnt",    64'(gnt_o),    64'(1));
    tick();
    rready_i = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    check("qflush_idle", 64'(rvalid_o), 64'(0));
    tick();

    // Write to the word being read in the same cycle returns the old data
    req_i  = 1'b1;
    addr_i = 32'h10;
    wait_gnt(ok);
    check("rw_gnt", 64'(ok), 64'(1));
    if (ok) exp_q.push_back({1'b0, 32'h0000_0000});
    tick();
    req_i = 1'b0;
    tick();
    wr_en_i   = 1'b1;
    wr_addr_i = 32'h10;
    wr_data_i = 32'hDEAD_BEEF;
    tick();
    wr_en_i = 1'b0;
    drain();
    fetch(32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1);
    drain();

`ifdef IMEM_PARITY_EN
    // Corrupt one stored data bit: raw word comes back flagged
    dut.mem_array[0] = dut.mem_array[0] ^ 33'h1;
    fetch(32'h0, 32'h0010_0092, 1'b1, 1'b1);
    drain();
`endif

    // Reset during the wait state drops the access
    req_i  = 1'b1;
    addr_i = 32'h0;
    wait_gnt(ok);
    check("rstw_gnt_acc", 64'(ok), 64'(1));
    tick();
    req_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstw_gnt", 64'(gnt_o), 64'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_rvalid", 64'(rvalid_o), 64'(0));
    repeat (4) tick();
    @(negedge clk);
    check("rstw_rvalid_late", 64'(rvalid_o), 64'(0));
    check("rstw_gnt_idle",    64'(gnt_o),    64'(1));

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
